capture_sequencer: RTL and testbench
====================================

Name: capture_sequencer

Overview:
- Sequences the camera capture datapath: gates its start/end inputs so capture begins only after sensor configuration has completed and exposure has settled.
- Supports single-shot (N-frame snapshot) and continuous capture; ends capture cleanly on frame boundaries.
- Watchdogs the frame-valid (VSYNC) line and reports timeouts.
- Sits between the SCCB config controller, user/host control, and the capture block; runs in the capture block's clock domain.

Parameters:
- SETTLE_FRAMES, 10: frame-start events to discard after config done before capture is allowed.
- TIMEOUT_CYCLES, 2000000: iCLK cycles with no iFVAL edge before a timeout is declared. Counter width is 24 bits; the value must be >= 1.

Ports:
- iCLK  in  1  clock, same domain as the capture block.
- iRST  in  1  asynchronous, active-low reset.
- iCFG_DONE  in  1  level, high while sensor registers are configured.
- iFVAL  in  1  raw frame-valid/VSYNC; 1->0 = frame start event, 0->1 = frame end event.
- iRUN  in  1  level request for continuous capture.
- iSNAP  in  1  one-cycle pulse requesting a snapshot.
- iSNAP_NUM  in  8  frames per snapshot, sampled with iSNAP; 0 = request ignored.
- iSTOP  in  1  one-cycle pulse: stop run / clear error.
- oSTART  out  1  one-cycle pulse to capture block start input.
- oEND  out  1  one-cycle pulse to capture block end input.
- oBUSY  out  1  high in RUN or DRAIN.
- oSTATE  out  3  current state encoding.
- oTIMEOUT  out  1  sticky timeout flag.
- oFRAMES_DONE  out  8  frames completed in the current/last run, saturating at 255.

Behaviour:
- All outputs are registered. Reset values: oSTART=0, oEND=0, oBUSY=0, oSTATE=0, oTIMEOUT=0, oFRAMES_DONE=0. All counters clear on reset.
- iFVAL is delayed one register for edge detect, so events align with the capture block's own frame detection.
- States: WAIT_CFG=0, SETTLE=1, READY=2, RUN=3, DRAIN=4, ERROR=5.
- WAIT_CFG:
  - iCFG_DONE=1 -> SETTLE; settle counter cleared.
- SETTLE:
  - Count frame start events.
  - After SETTLE_FRAMES events -> READY. With SETTLE_FRAMES=0, go to READY on the next cycle.
- READY:
  - Accepted requests: iSNAP with iSNAP_NUM!=0 (snapshot mode, target latched), or iRUN=1 (continuous mode).
  - If both occur in the same cycle, iSNAP wins.
  - On an accepted request: oSTART pulses the following cycle, state -> RUN, oFRAMES_DONE cleared, in_frame cleared.
- RUN:
  - A frame start event sets in_frame.
  - A frame end event with in_frame=1 increments oFRAMES_DONE and clears in_frame. A frame already in progress at start is therefore not counted.
  - Snapshot: when the increment reaches the target, oEND pulses the next cycle and state -> READY.
  - Continuous: iRUN=0 or iSTOP -> DRAIN.
  - Snapshot: iSTOP -> DRAIN.
- DRAIN:
  - If in_frame=0, oEND next cycle -> READY.
  - Otherwise wait for the frame end event (counted), then oEND next cycle -> READY.
- Timeout:
  - In SETTLE, RUN and DRAIN, the watchdog counter clears on any iFVAL edge and on state entry.
  - Reaching TIMEOUT_CYCLES -> ERROR, oTIMEOUT=1. oEND pulses if the timeout came from RUN or DRAIN.
  - Watchdog is idle in other states.
- ERROR:
  - iSTOP -> SETTLE, clears oTIMEOUT.
- Config loss: iCFG_DONE=0 in any state other than WAIT_CFG -> WAIT_CFG. oEND pulses if it occurred in RUN or DRAIN. oTIMEOUT is held.
- Priority per cycle: config loss > timeout > iSTOP > frame events > new requests.
- oSTART and oEND are never asserted in the same cycle. Each is exactly one cycle wide.
- oBUSY = (state==RUN or DRAIN).
- Requests arriving outside READY are dropped, not queued.
- Reset mid-run: everything returns to WAIT_CFG immediately with no oEND pulse. The capture block is reset on the same iRST.

Test Plan:
1. Reset, iCFG_DONE=1, SETTLE_FRAMES=3, generate 4 frames -> oSTATE 0->1, READY (2) on the 3rd frame start.
2. In READY, iSNAP with iSNAP_NUM=2 issued mid-frame -> oSTART one cycle later. The partial frame is not counted. oEND one cycle after the 2nd full frame end; oFRAMES_DONE=2; back to READY.
3. iRUN=1 for 5 frames, then drop iRUN mid-frame -> DRAIN. oEND one cycle after that frame ends; oFRAMES_DONE=6.
4. TIMEOUT_CYCLES=100, start continuous, hold iFVAL static -> ERROR at watchdog cycle 100, oTIMEOUT=1, single oEND pulse. Then iSTOP -> SETTLE, oTIMEOUT=0.
5. Drop iCFG_DONE during RUN, simultaneous with a frame end -> WAIT_CFG with oEND pulse; the frame is not counted; oBUSY=0.
6. iSNAP (NUM=1) and iRUN rise in the same READY cycle -> snapshot mode, exactly one frame captured. iSNAP with NUM=0 -> no oSTART.

Source files
------------

// File: rtl/capture_sequencer.sv
// Capture sequencer: gates the capture block's start/end strobes so capture
// only begins after the sensor is configured and exposure has settled.
// Handles N-frame snapshots and continuous capture, always ending on a frame
// boundary. It also watchdogs the frame-valid line and reports stalls.
module capture_sequencer #(
    parameter int SETTLE_FRAMES  = 10,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iCFG_DONE,
    input  logic       iFVAL,
    input  logic       iRUN,
    input  logic       iSNAP,
    input  logic [7:0] iSNAP_NUM,
    input  logic       iSTOP,
    output logic       oSTART,
    output logic       oEND,
    output logic       oBUSY,
    output logic [2:0] oSTATE,
    output logic       oTIMEOUT,
    output logic [7:0] oFRAMES_DONE
);

    typedef enum logic [2:0] {
        WAIT_CFG = 3'd0,
        SETTLE   = 3'd1,
        READY    = 3'd2,
        RUN      = 3'd3,
        DRAIN    = 3'd4,
        ERROR    = 3'd5
    } state_t;

    // The watchdog fires when the counter would reach TIMEOUT_CYCLES.
    localparam logic [23:0] WD_LAST    = 24'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] SETTLE_TGT = 16'(SETTLE_FRAMES);

    state_t      state_q,     state_d;
    logic        fval_q,      fval_d;
    logic [15:0] settle_q,    settle_d;
    logic [23:0] wd_q,        wd_d;
    logic [7:0]  frames_q,    frames_d;
    logic [7:0]  target_q,    target_d;
    logic        snap_mode_q, snap_mode_d;
    logic        in_frame_q,  in_frame_d;
    logic        start_q,     start_d;
    logic        end_q,       end_d;
    logic        busy_q,      busy_d;
    logic        timeout_q,   timeout_d;

    // Frame events from the one-cycle delayed frame-valid; VSYNC is low
    // during a frame, so a falling edge starts a frame.
    logic       frame_start;
    logic       frame_end;
    logic       fval_edge;
    logic       wd_active;
    logic       wd_expired;
    logic       in_capture;
    logic       req_snap;
    logic [7:0] frames_inc;

    assign frame_start = fval_q & ~iFVAL;
    assign frame_end   = ~fval_q & iFVAL;
    assign fval_edge   = fval_q ^ iFVAL;
    assign wd_active   = (state_q == SETTLE) || (state_q == RUN) || (state_q == DRAIN);
    assign wd_expired  = wd_active && !fval_edge && (wd_q == WD_LAST);
    assign in_capture  = (state_q == RUN) || (state_q == DRAIN);
    assign req_snap    = iSNAP && (iSNAP_NUM != 8'd0);
    assign frames_inc  = (frames_q == 8'hFF) ? frames_q : frames_q + 8'd1;

    // Next-state logic: config loss, then timeout, then stop, then frame
    // events, then new requests.
    always_comb begin
        state_d     = state_q;
        fval_d      = iFVAL;
        settle_d    = settle_q;
        frames_d    = frames_q;
        target_d    = target_q;
        snap_mode_d = snap_mode_q;
        in_frame_d  = in_frame_q;
        start_d     = 1'b0;
        end_d       = 1'b0;
        timeout_d   = timeout_q;

        if (state_q != WAIT_CFG && !iCFG_DONE) begin
            // Sensor lost its configuration: abandon whatever we were doing,
            // but close an open capture so the capture block sees an end.
            state_d = WAIT_CFG;
            end_d   = in_capture;
        end else if (wd_expired) begin
            state_d   = ERROR;
            timeout_d = 1'b1;
            end_d     = in_capture;
        end else begin
            case (state_q)
                WAIT_CFG: begin
                    if (iCFG_DONE) begin
                        state_d  = SETTLE;
                        settle_d = 16'd0;
                    end
                end
                SETTLE: begin
                    if (SETTLE_TGT == 16'd0) begin
                        state_d = READY;
                    end else if (frame_start) begin
                        if (settle_q + 16'd1 == SETTLE_TGT) begin
                            state_d = READY;
                        end else begin
                            settle_d = settle_q + 16'd1;
                        end
                    end
                end
                READY: begin
                    // A stop pulse in this cycle suppresses any request.
                    if (!iSTOP && (req_snap || iRUN)) begin
                        state_d     = RUN;
                        start_d     = 1'b1;
                        frames_d    = 8'd0;
                        in_frame_d  = 1'b0;
                        snap_mode_d = req_snap;
                        if (req_snap) begin
                            target_d = iSNAP_NUM;
                        end
                    end
                end
                RUN: begin
                    if (iSTOP || (!snap_mode_q && !iRUN)) begin
                        state_d = DRAIN;
                    end else if (frame_start) begin
                        in_frame_d = 1'b1;
                    end else if (frame_end && in_frame_q) begin
                        frames_d   = frames_inc;
                        in_frame_d = 1'b0;
                        if (snap_mode_q && frames_inc == target_q) begin
                            state_d = READY;
                            end_d   = 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (!in_frame_q) begin
                        state_d = READY;
                        end_d   = 1'b1;
                    end else if (frame_end) begin
                        frames_d   = frames_inc;
                        in_frame_d = 1'b0;
                        state_d    = READY;
                        end_d      = 1'b1;
                    end
                end
                ERROR: begin
                    if (iSTOP) begin
                        state_d   = SETTLE;
                        settle_d  = 16'd0;
                        timeout_d = 1'b0;
                    end
                end
                default: begin
                    state_d = WAIT_CFG;
                end
            endcase
        end

        // Watchdog restarts on any frame-valid edge and on every state change.
        if (wd_active && state_d == state_q && !fval_edge) begin
            wd_d = wd_q + 24'd1;
        end else begin
            wd_d = 24'd0;
        end

        busy_d = (state_d == RUN) || (state_d == DRAIN);
    end

    // State and output registers.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q     <= WAIT_CFG;
            fval_q      <= 1'b0;
            settle_q    <= 16'd0;
            wd_q        <= 24'd0;
            frames_q    <= 8'd0;
            target_q    <= 8'd0;
            snap_mode_q <= 1'b0;
            in_frame_q  <= 1'b0;
            start_q     <= 1'b0;
            end_q       <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            fval_q      <= fval_d;
            settle_q    <= settle_d;
            wd_q        <= wd_d;
            frames_q    <= frames_d;
            target_q    <= target_d;
            snap_mode_q <= snap_mode_d;
            in_frame_q  <= in_frame_d;
            start_q     <= start_d;
            end_q       <= end_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
        end
    end

    assign oSTART       = start_q;
    assign oEND         = end_q;
    assign oBUSY        = busy_q;
    assign oSTATE       = state_q;
    assign oTIMEOUT     = timeout_q;
    assign oFRAMES_DONE = frames_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer: scenario tasks drive randomized frame timing
// and compare outputs against expectations derived from frame counts.
module tb_capture_sequencer;

    localparam int SETTLE = 3;
    localparam int TMO    = 100;

    localparam logic [2:0] S_WAIT   = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_READY  = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_ERROR  = 3'd5;

    logic       iCLK, iRST, iCFG_DONE, iFVAL, iRUN, iSNAP, iSTOP;
    logic [7:0] iSNAP_NUM;
    logic       oSTART, oEND, oBUSY, oTIMEOUT;
    logic [2:0] oSTATE;
    logic [7:0] oFRAMES_DONE;

    int n_vec = 0;
    int n_err = 0;
    int start_cnt = 0;
    int end_cnt = 0;
    int overlap_cnt = 0;

    capture_sequencer #(
        .SETTLE_FRAMES (SETTLE),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .iCFG_DONE   (iCFG_DONE),
        .iFVAL       (iFVAL),
        .iRUN        (iRUN),
        .iSNAP       (iSNAP),
        .iSNAP_NUM   (iSNAP_NUM),
        .iSTOP       (iSTOP),
        .oSTART      (oSTART),
        .oEND        (oEND),
        .oBUSY       (oBUSY),
        .oSTATE      (oSTATE),
        .oTIMEOUT    (oTIMEOUT),
        .oFRAMES_DONE(oFRAMES_DONE)
    );

    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    // Pulse monitor, sampled on the falling edge.
    always @(negedge iCLK) begin
        if (oSTART) start_cnt++;
        if (oEND) end_cnt++;
        if (oSTART && oEND) overlap_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, want finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // DUT has just entered SETTLE: play SETTLE+1 frames, READY expected
    // right after the SETTLE-th frame start.
    task automatic settle_seq(input string tag);
        logic [2:0] exp_s;
        int lo, hi;
        for (int k = 1; k <= SETTLE + 1; k++) begin
            lo = $urandom_range(2, 12);
            hi = $urandom_range(2, 12);
            iFVAL = 1'b0;
            tick();
            exp_s = (k >= SETTLE) ? S_READY : S_SETTLE;
            n_vec++;
            if (oSTATE !== exp_s) begin
                n_err++;
                $display("FAIL %s_settle_state frame %0d: got %0d want %0d", tag, k, oSTATE, exp_s);
            end
            ticks(lo - 1);
            iFVAL = 1'b1;
            ticks(hi);
        end
        $display("settle %s: %0d frames played, state=%0d", tag, SETTLE + 1, oSTATE);
    endtask

    task automatic test_reset();
        iRST = 1'b0; iCFG_DONE = 1'b0; iFVAL = 1'b1; iRUN = 1'b0;
        iSNAP = 1'b0; iSNAP_NUM = 8'd0; iSTOP = 1'b0;
        ticks(3);
        n_vec++; if (oSTATE !== S_WAIT) begin n_err++; $display("FAIL reset_state: got %0d want 0", oSTATE); end
        n_vec++; if (oSTART !== 1'b0) begin n_err++; $display("FAIL reset_start: got %b want 0", oSTART); end
        n_vec++; if (oEND !== 1'b0) begin n_err++; $display("FAIL reset_end: got %b want 0", oEND); end
        n_vec++; if (oBUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", oBUSY); end
        n_vec++; if (oTIMEOUT !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b want 0", oTIMEOUT); end
        n_vec++; if (oFRAMES_DONE !== 8'd0) begin n_err++; $display("FAIL reset_frames: got %0d want 0", oFRAMES_DONE); end
        iRST = 1'b1;
        ticks(3);
        n_vec++; if (oSTATE !== S_WAIT) begin n_err++; $display("FAIL wait_cfg_hold: got %0d want 0", oSTATE); end
        $display("reset: state=%0d", oSTATE);
    endtask

    task automatic test_settle();
        iCFG_DONE = 1'b1;
        tick();
        n_vec++; if (oSTATE !== S_SETTLE) begin n_err++; $display("FAIL cfg_to_settle: got %0d want 1", oSTATE); end
        settle_seq("initial");
    endtask

    task automatic test_snapshot();
        int s0, e0, lo, hi;
        s0 = start_cnt; e0 = end_cnt;
        iFVAL = 1'b0;
        ticks(2);
        iSNAP = 1'b1; iSNAP_NUM = 8'd2;
        tick();
        iSNAP = 1'b0; iSNAP_NUM = 8'd0;
        n_vec++; if (oSTART !== 1'b1) begin n_err++; $display("FAIL snap_start: got %b want 1", oSTART); end
        n_vec++; if (oSTATE !== S_RUN) begin n_err++; $display("FAIL snap_run: got %0d want 3", oSTATE); end
        tick();
        n_vec++; if (oSTART !== 1'b0) begin n_err++; $display("FAIL snap_start_width: got %b want 0", oSTART); end
        ticks($urandom_range(2, 8));
        iFVAL = 1'b1;
        tick();
        n_vec++; if (oFRAMES_DONE !== 8'd0) begin n_err++; $display("FAIL snap_partial: got %0d want 0", oFRAMES_DONE); end
        ticks($urandom_range(2, 8));
        for (int f = 1; f <= 2; f++) begin
            lo = $urandom_range(2, 15);
            hi = $urandom_range(2, 15);
            iFVAL = 1'b0;
            ticks(lo);
            iFVAL = 1'b1;
            tick();
            n_vec++; if (oFRAMES_DONE !== 8'(f)) begin n_err++; $display("FAIL snap_frames %0d: got %0d want %0d", f, oFRAMES_DONE, f); end
            n_vec++; if (oEND !== (f == 2)) begin n_err++; $display("FAIL snap_end %0d: got %b want %b", f, oEND, (f == 2)); end
            n_vec++; if (oSTATE !== ((f == 2) ? S_READY : S_RUN)) begin n_err++; $display("FAIL snap_state %0d: got %0d", f, oSTATE); end
            ticks(hi - 1);
        end
        n_vec++; if (end_cnt - e0 !== 1) begin n_err++; $display("FAIL snap_end_count: got %0d want 1", end_cnt - e0); end
        n_vec++; if (start_cnt - s0 !== 1) begin n_err++; $display("FAIL snap_start_count: got %0d want 1", start_cnt - s0); end
        $display("snapshot num=2: frames=%0d state=%0d", oFRAMES_DONE, oSTATE);
    endtask

    task automatic test_continuous();
        int n, lo, hi;
        n = $urandom_range(3, 6);
        iRUN = 1'b1;
        tick();
        n_vec++; if (oSTART !== 1'b1 || oSTATE !== S_RUN) begin n_err++; $display("FAIL cont_start: start=%b state=%0d want 1/3", oSTART, oSTATE); end
        for (int f = 1; f <= n; f++) begin
            lo = $urandom_range(2, 15);
            hi = $urandom_range(2, 15);
            iFVAL = 1'b0;
            ticks(lo);
            iFVAL = 1'b1;
            tick();
            n_vec++; if (oFRAMES_DONE !== 8'(f) || oEND !== 1'b0) begin n_err++; $display("FAIL cont_frame %0d: frames=%0d end=%b want %0d/0", f, oFRAMES_DONE, oEND, f); end
            ticks(hi - 1);
        end
        iFVAL = 1'b0;
        ticks(3);
        iRUN = 1'b0;
        tick();
        n_vec++; if (oSTATE !== S_DRAIN || oBUSY !== 1'b1) begin n_err++; $display("FAIL cont_drain: state=%0d busy=%b want 4/1", oSTATE, oBUSY); end
        ticks($urandom_range(2, 10));
        n_vec++; if (oEND !== 1'b0) begin n_err++; $display("FAIL cont_early_end: got %b want 0", oEND); end
        iFVAL = 1'b1;
        tick();
        n_vec++; if (oEND !== 1'b1 || oSTATE !== S_READY) begin n_err++; $display("FAIL cont_end: end=%b state=%0d want 1/2", oEND, oSTATE); end
        n_vec++; if (oFRAMES_DONE !== 8'(n + 1)) begin n_err++; $display("FAIL cont_frames: got %0d want %0d", oFRAMES_DONE, n + 1); end
        n_vec++; if (oBUSY !== 1'b0) begin n_err++; $display("FAIL cont_busy: got %b want 0", oBUSY); end
        ticks(3);
        $display("continuous: %0d full frames then drain, frames=%0d", n, oFRAMES_DONE);
    endtask

    task automatic test_timeout();
        int waited, e0;
        iRUN = 1'b1;
        tick();
        n_vec++; if (oSTATE !== S_RUN) begin n_err++; $display("FAIL tmo_run: got %0d want 3", oSTATE); end
        e0 = end_cnt;
        waited = 0;
        while (oSTATE !== S_ERROR && waited < 3 * TMO) begin
            tick();
            waited++;
        end
        n_vec++; if (waited !== TMO) begin n_err++; $display("FAIL tmo_latency: got %0d cycles want %0d", waited, TMO); end
        n_vec++; if (oTIMEOUT !== 1'b1) begin n_err++; $display("FAIL tmo_flag: got %b want 1", oTIMEOUT); end
        n_vec++; if (oEND !== 1'b1 || oBUSY !== 1'b0) begin n_err++; $display("FAIL tmo_end: end=%b busy=%b want 1/0", oEND, oBUSY); end
        iRUN = 1'b0;
        tick();
        n_vec++; if (oEND !== 1'b0 || oTIMEOUT !== 1'b1) begin n_err++; $display("FAIL tmo_sticky: end=%b tmo=%b want 0/1", oEND, oTIMEOUT); end
        ticks(2);
        n_vec++; if (end_cnt - e0 !== 1) begin n_err++; $display("FAIL tmo_end_count: got %0d want 1", end_cnt - e0); end
        iSTOP = 1'b1;
        tick();
        iSTOP = 1'b0;
        n_vec++; if (oSTATE !== S_SETTLE || oTIMEOUT !== 1'b0) begin n_err++; $display("FAIL tmo_clear: state=%0d tmo=%b want 1/0", oSTATE, oTIMEOUT); end
        $display("timeout: error after %0d cycles", waited);
        settle_seq("after_error");
    endtask

    task automatic test_cfg_loss();
        int lo, hi;
        lo = $urandom_range(2, 12);
        hi = $urandom_range(2, 12);
        iRUN = 1'b1;
        tick();
        iFVAL = 1'b0;
        ticks(lo);
        iFVAL = 1'b1;
        tick();
        n_vec++; if (oFRAMES_DONE !== 8'd1) begin n_err++; $display("FAIL cfg_first_frame: got %0d want 1", oFRAMES_DONE); end
        ticks(hi - 1);
        iFVAL = 1'b0;
        ticks(lo);
        iFVAL = 1'b1; iCFG_DONE = 1'b0; iRUN = 1'b0;
        tick();
        n_vec++; if (oSTATE !== S_WAIT || oEND !== 1'b1) begin n_err++; $display("FAIL cfg_loss: state=%0d end=%b want 0/1", oSTATE, oEND); end
        n_vec++; if (oBUSY !== 1'b0) begin n_err++; $display("FAIL cfg_busy: got %b want 0", oBUSY); end
        n_vec++; if (oFRAMES_DONE !== 8'd1) begin n_err++; $display("FAIL cfg_uncounted: got %0d want 1", oFRAMES_DONE); end
        tick();
        n_vec++; if (oEND !== 1'b0) begin n_err++; $display("FAIL cfg_end_width: got %b want 0", oEND); end
        iCFG_DONE = 1'b1;
        tick();
        n_vec++; if (oSTATE !== S_SETTLE) begin n_err++; $display("FAIL cfg_resettle: got %0d want 1", oSTATE); end
        $display("config loss: frames=%0d", oFRAMES_DONE);
        settle_seq("after_cfg_loss");
    endtask

    task automatic test_priority();
        int s0;
        iSNAP = 1'b1; iSNAP_NUM = 8'd1; iRUN = 1'b1;
        tick();
        iSNAP = 1'b0; iSNAP_NUM = 8'd0;
        n_vec++; if (oSTART !== 1'b1 || oSTATE !== S_RUN) begin n_err++; $display("FAIL prio_start: start=%b state=%0d", oSTART, oSTATE); end
        iFVAL = 1'b0;
        ticks($urandom_range(2, 12));
        iFVAL = 1'b1; iRUN = 1'b0;
        tick();
        n_vec++; if (oSTATE !== S_READY || oEND !== 1'b1) begin n_err++; $display("FAIL prio_snap_end: state=%0d end=%b want 2/1", oSTATE, oEND); end
        n_vec++; if (oFRAMES_DONE !== 8'd1) begin n_err++; $display("FAIL prio_frames: got %0d want 1", oFRAMES_DONE); end
        ticks(3);
        s0 = start_cnt;
        iSNAP = 1'b1; iSNAP_NUM = 8'd0;
        tick();
        iSNAP = 1'b0;
        n_vec++; if (oSTART !== 1'b0 || oSTATE !== S_READY) begin n_err++; $display("FAIL snap_zero: start=%b state=%0d want 0/2", oSTART, oSTATE); end
        ticks(2);
        n_vec++; if (start_cnt !== s0) begin n_err++; $display("FAIL snap_zero_count: got %0d want %0d", start_cnt, s0); end
        $display("priority: snapshot won, num=0 ignored");
    endtask

    task automatic test_back_to_back();
        int num, lo, hi;
        for (int r = 0; r < 3; r++) begin
            num = $urandom_range(1, 4);
            iSNAP = 1'b1; iSNAP_NUM = 8'(num);
            tick();
            iSNAP = 1'b0; iSNAP_NUM = 8'd0;
            n_vec++; if (oSTART !== 1'b1) begin n_err++; $display("FAIL b2b_start %0d: got %b want 1", r, oSTART); end
            for (int f = 1; f <= num; f++) begin
                lo = $urandom_range(2, 10);
                hi = $urandom_range(2, 10);
                iFVAL = 1'b0;
                ticks(lo);
                iFVAL = 1'b1;
                tick();
                n_vec++; if (oFRAMES_DONE !== 8'(f) || oEND !== (f == num)) begin
                    n_err++; $display("FAIL b2b_frame %0d.%0d: frames=%0d end=%b want %0d/%b", r, f, oFRAMES_DONE, oEND, f, (f == num));
                end
                if (f < num) ticks(hi - 1);
            end
            $display("back_to_back %0d: num=%0d frames=%0d", r, num, oFRAMES_DONE);
        end
        ticks(2);
    endtask

    task automatic test_reset_midrun();
        int e0;
        iRUN = 1'b1;
        tick();
        iFVAL = 1'b0;
        ticks(3);
        e0 = end_cnt;
        iRST = 1'b0;
        #1;
        n_vec++; if (oSTATE !== S_WAIT || oBUSY !== 1'b0 || oEND !== 1'b0) begin
            n_err++; $display("FAIL async_reset: state=%0d busy=%b end=%b want 0/0/0", oSTATE, oBUSY, oEND);
        end
        ticks(2);
        iRUN = 1'b0; iFVAL = 1'b1; iRST = 1'b1;
        ticks(3);
        n_vec++; if (end_cnt !== e0) begin n_err++; $display("FAIL reset_no_end: got %0d want %0d", end_cnt, e0); end
        n_vec++; if (overlap_cnt !== 0) begin n_err++; $display("FAIL start_end_overlap: got %0d want 0", overlap_cnt); end
        $display("reset mid-run: state=%0d", oSTATE);
    endtask

    initial begin
        test_reset();
        test_settle();
        test_snapshot();
        test_continuous();
        test_timeout();
        test_cfg_loss();
        test_priority();
        test_back_to_back();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
